// File: rtl/vending_input_cond.sv
// vending_input_cond: sync/debounce of raw buttons, press pulses, coin FIFO and tick (optional VENDING_AUTOREPEAT_EN)
module vending_input_cond #(
  parameter int DEB_CYCLES = 1000000,
  parameter int TICK_DIV = 6000000,
  parameter int FIFO_DEPTH = 4
`ifdef VENDING_AUTOREPEAT_EN
  , parameter int REPEAT_CYCLES = 50000000
`endif
) (
  input  logic clk,
  input  logic SW3,
  input  logic L,
  input  logic R,
  input  logic U,
  input  logic D,
  input  logic SW0,
  input  logic SW1,
  input  logic SW2,
  input  logic coin_ready,
  output logic coin_valid,
  output logic [1:0] coin_val,
  output logic [$clog2(FIFO_DEPTH):0] coin_level,
  output logic coin_ovf,
  output logic refund_pulse,
  output logic down_pulse,
  output logic [2:0] sel_pulse,
  output logic tick
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [6:0] raw, sync1_q, sync2_q, stable_q, stable_d, prev_q, press_q, press_d;
  logic [DW-1:0] deb_cnt_q [7];
  logic [DW-1:0] deb_cnt_d [7];
  logic [1:0] mem_q [FIFO_DEPTH];
  logic [1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic coin_valid_q, coin_valid_d, ovf_q, ovf_d;
  logic [1:0] push_val;
  logic push, pop, flush, full, accept;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  assign raw = {SW2, SW1, SW0, D, U, R, L};

  // per-input debounce: stable follows synced after DEB_CYCLES consecutive differing cycles
  always_comb begin
    stable_d = stable_q;
    press_d = prev_q & ~stable_q;
    for (int i = 0; i < 7; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_MAX) stable_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // synchroniser, debounce state and registered press pulses
  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) begin
      sync1_q <= '1;
      sync2_q <= '1;
      stable_q <= '1;
      prev_q <= '1;
      press_q <= '0;
      for (int i = 0; i < 7; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      prev_q <= stable_q;
      press_q <= press_d;
      for (int i = 0; i < 7; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

`ifdef VENDING_AUTOREPEAT_EN
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0] held, rep_val;

  // repeat timer restarts on each coin press and clears on release
  always_comb begin
    held = ~stable_q[1:0];
    rep_val = (|held && !(|press_q[1:0]) && rep_cnt_q == REP_MAX) ? held : 2'b00;
    rep_cnt_d = (!(|held) || |press_q[1:0] || rep_cnt_q == REP_MAX) ? '0 : rep_cnt_q + 1'b1;
    push_val = press_q[1:0] | rep_val;
  end

  // repeat timer register
  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) rep_cnt_q <= '0;
    else rep_cnt_q <= rep_cnt_d;
  end
`else
  assign push_val = press_q[1:0];
`endif

  // coin FIFO next state: refund flush first, then push/pop with overflow tracking
  always_comb begin
    push = |push_val;
    flush = press_q[2];
    pop = coin_valid_q & coin_ready;
    full = level_q == LW'(FIFO_DEPTH);
    accept = push & (flush | ~full | pop);
    mem_d = mem_q;
    if (accept) mem_d[wptr_q] = push_val;
    wptr_d = wptr_q + AW'(accept);
    rptr_d = flush ? wptr_q : rptr_q + AW'(pop);
    level_d = flush ? LW'(accept) : level_q + LW'(accept) - LW'(pop);
    ovf_d = ovf_q | (push & ~accept);
    coin_valid_d = level_d != '0;
  end

  // coin FIFO registers
  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ovf_q <= 1'b0;
      coin_valid_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      ovf_q <= ovf_d;
      coin_valid_q <= coin_valid_d;
    end
  end

  // free-running tick divider
  always_comb tick_cnt_d = tick_cnt_q == TICK_MAX ? '0 : tick_cnt_q + 1'b1;

  // tick counter register
  always_ff @(posedge clk or negedge SW3) begin
    if (!SW3) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_d;
  end

  assign tick = tick_cnt_q == TICK_MAX;
  assign coin_valid = coin_valid_q;
  assign coin_val = coin_valid_q ? mem_q[rptr_q] : 2'b00;
  assign coin_level = level_q;
  assign coin_ovf = ovf_q;
  assign refund_pulse = press_q[2];
  assign down_pulse = press_q[3];
  assign sel_pulse = press_q[6:4];
endmodule

// File: doc/vending_input_cond.md
Name: vending_input_cond

Overview:
Upstream front-end for the vending controller. Synchronises and debounces the raw active-low push-buttons (L, R, U, D) and item-select switches (SW0..SW2), then converts presses into clean one-cycle event pulses. Coin presses are queued in a small FIFO with a valid/ready handshake toward the credit/dispense stage. The block also generates the slow state-machine clock-enable tick, so the downstream stage runs entirely on clk.

Parameters:
DEB_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz)
TICK_DIV, 6000000, tick period in clk cycles
FIFO_DEPTH, 4, coin-event queue depth (power of two, >=2)
REPEAT_CYCLES, 50000000, auto-repeat interval; used only with the optional feature

Ports:
clk  in  1  system clock
SW3  in  1  reset; asynchronous assert, active-low (also the machine restock/clear switch)
L  in  1  raw button, active-low; coin of 1 unit (500 won)
R  in  1  raw button, active-low; coin of 2 units
U  in  1  raw button, active-low; refund request
D  in  1  raw button, active-low; spare/cancel
SW0  in  1  raw select switch, active-low
SW1  in  1  raw select switch, active-low
SW2  in  1  raw select switch, active-low
coin_ready  in  1  downstream accepts head coin this cycle
coin_valid  out  1  FIFO non-empty
coin_val  out  2  head coin value in units: 1, 2, or 3
coin_level  out  clog2(FIFO_DEPTH)+1  entries queued
coin_ovf  out  1  sticky: a coin was dropped because the queue was full
refund_pulse  out  1  one-cycle U press
down_pulse  out  1  one-cycle D press
sel_pulse  out  3  one-cycle press of SW2..SW0 (bit i = SWi)
tick  out  1  one-cycle enable every TICK_DIV cycles

Behaviour:
- Reset (SW3=0, asynchronous): all outputs 0. FIFO is empty. Tick and debounce counters are 0. Synchroniser and stable registers are set to 1 (released).
- Synchroniser: two flops per raw input.
- Debounce, per input: if synced != stable, the counter increments; otherwise the counter clears. When the counter reaches DEB_CYCLES-1 while still differing, stable takes the synced value and the counter clears. A glitch shorter than DEB_CYCLES cycles never changes stable.
- Press event: stable transitions 1->0, registered as a one-cycle pulse. Fixed latency from the first clk edge sampling the held-low raw input to the pulse is DEB_CYCLES+3 cycles. Release (0->1) produces no event.
- Coin encoding on the same cycle: L press only pushes 1; R press only pushes 2; L and R together push a single entry of 3.
- FIFO:
  - coin_valid is registered, not combinational.
  - An entry pushed in cycle N is visible on coin_val and coin_valid in cycle N+1.
  - A pop occurs when coin_valid && coin_ready.
  - Push while full with no pop: the entry is dropped and coin_ovf is set to 1. coin_ovf stays set until reset.
  - Push while full with a simultaneous pop: the push is accepted and the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Refund: a U press asserts refund_pulse and flushes the FIFO. Pending unaccepted coins are discarded, and coin_valid is 0 in the next cycle. A coin push in the same cycle as the flush is enqueued after the flush, leaving level 1.
- sel_pulse bits and down_pulse are independent and may assert in the same cycle.
- tick: counter counts 0..TICK_DIV-1. tick=1 exactly when the counter equals TICK_DIV-1, then the counter wraps to 0. The first tick after reset is at cycle TICK_DIV.
- Reset mid-operation: events in flight are lost, and no pulse is emitted on reset release.

Optional Feature:
VENDING_AUTOREPEAT_EN:
- Defined: while L or R stays debounced-low, one additional entry of the same value is pushed every REPEAT_CYCLES cycles after the initial press. The repeat counter restarts on each new press and clears on release. Repeat pushes follow the same full/ovf rules as normal pushes.
- Undefined: exactly one entry per press, and no repeat logic is synthesised.

Test Plan:
Test parameters: DEB_CYCLES=4, TICK_DIV=8, FIFO_DEPTH=4.
1. L low for 3 cycles (bounce) -> no push. L low held for 10 cycles -> pulse 7 cycles after first low, then exactly one entry coin_val=1, coin_level=1.
2. Five L presses with coin_ready=0 -> coin_level=4 and coin_ovf=1. Then coin_ready=1 -> four pops of 1 on consecutive cycles, coin_valid=0 afterwards, coin_ovf stays 1.
3. L and R debounced on the same cycle -> single entry coin_val=3, coin_level=1.
4. Two entries queued, then U press -> refund_pulse high for 1 cycle, next cycle coin_valid=0 and coin_level=0.
5. Free-run -> tick at cycles 8, 16, 24. Drive SW3 low at cycle 19 -> all outputs 0 immediately. Release -> next tick 8 cycles after release.
6. SW1 pressed and held for 20 cycles -> sel_pulse=3'b010 for exactly one cycle, with no further pulses while held or on release.
